// File: rtl/uart_rx.sv
// uart_rx: memory-mapped 8N1 UART receiver with a receive FIFO.
//   clk, rst      : system clock, synchronous active-high reset
//   addr          : bus address, only addr[3:2] decoded
//                   (0 DATA, 1 STATUS, 2 CTRL, 3 reserved)
//   write_data    : bus write data
//   write_enable  : register write strobe
//   read_enable   : register read strobe
//   read_data     : register read data, combinational while read_enable=1
//   rx_valid      : read acknowledge, high the cycle after a read cycle
//   rx            : asynchronous serial input, idle high
//   rx_interrupt  : registered level interrupt
module uart_rx #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  input  logic        read_enable,
  output logic [31:0] read_data,
  output logic        rx_valid,
  input  logic        rx,
  output logic        rx_interrupt
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CLK_CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  // Receiver state
  logic                 rx_meta;
  logic                 rx_s;
  state_t               state_q, state_d;
  logic [CLK_CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic                 push_c;
  logic                 frame_set_c;

  // Register / FIFO state
  logic                 rx_en_q;
  logic                 irq_en_q;
  logic                 overrun_q;
  logic                 frame_err_q;
  logic                 hold_q;
  logic [7:0]           mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]     count_q;

  logic                 data_sel;
  logic                 status_sel;
  logic                 ctrl_sel;
  logic                 not_empty;
  logic                 full;
  logic                 pop_c;
  logic                 accept_c;
  logic                 overrun_set_c;
  logic                 status_wr_c;
  logic [31:0]          status_word;

  // Only addr[3:2] and the low control bits of write_data are meaningful
  logic unused_bits;
  assign unused_bits = ^{addr[31:4], addr[1:0], write_data[31:4]};

  // Two-flop synchroniser; the line idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Receiver FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // Receiver FSM next state: mid-bit sampling, LSB first
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    push_c      = 1'b0;
    frame_set_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_en_q && !rx_s) begin
          state_d   = ST_START;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      ST_START: begin
        if (clk_cnt_q == CLK_CNT_W'(HALF_BIT - 1)) begin
          clk_cnt_d = '0;
          // A start bit that is high again at mid-bit was a glitch
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == CLK_CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (clk_cnt_q == CLK_CNT_W'(CLKS_PER_BIT - 1)) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            push_c  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_set_c = 1'b1;
            state_d     = ST_WAIT_HIGH;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      ST_WAIT_HIGH: begin
        // A held-low break must not look like a new start bit
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address decode and FIFO handshake
  assign data_sel      = (addr[3:2] == 2'd0);
  assign status_sel    = (addr[3:2] == 2'd1);
  assign ctrl_sel      = (addr[3:2] == 2'd2);
  assign not_empty     = (count_q != '0);
  assign full          = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop_c         = read_enable & data_sel & ~hold_q & not_empty;
  assign accept_c      = push_c & (~full | pop_c);
  assign overrun_set_c = push_c & full & ~pop_c;
  assign status_wr_c   = write_enable & status_sel;

  assign status_word = {16'd0, 8'(count_q), 4'd0, frame_err_q, overrun_q, full, not_empty};

  // Combinational read mux
  always_comb begin
    read_data = '0;
    if (read_enable) begin
      case (addr[3:2])
        2'd0:    read_data = not_empty ? {24'd0, mem[rd_ptr_q]} : 32'd0;
        2'd1:    read_data = status_word;
        2'd2:    read_data = {30'd0, irq_en_q, rx_en_q};
        default: read_data = '0;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (accept_c) begin
      mem[wr_ptr_q] <= shift_q;
    end
  end

  // FIFO pointers, control, status flags, ack and interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      hold_q       <= 1'b0;
      rx_en_q      <= 1'b1;
      irq_en_q     <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_valid     <= 1'b0;
      rx_interrupt <= 1'b0;
    end else begin
      if (accept_c) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({accept_c, pop_c})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // One pop per contiguous DATA read, however long it is held
      hold_q <= read_enable & data_sel;
      if (write_enable && ctrl_sel) begin
        rx_en_q  <= write_data[0];
        irq_en_q <= write_data[1];
      end
      // New error events win over a simultaneous clear
      overrun_q   <= overrun_set_c | (overrun_q & ~(status_wr_c & write_data[2]));
      frame_err_q <= frame_set_c | (frame_err_q & ~(status_wr_c & write_data[3]));
      rx_valid     <= read_enable;
      rx_interrupt <= irq_en_q & (not_empty | overrun_q | frame_err_q);
    end
  end

endmodule
